// File: rtl/ld3320_bus_responder_pkg.sv
// Shared LD3320 constants: register addresses, status codes and responder FSM states.
package ld3320_bus_responder_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DATA_W-1:0] REG_START  = 8'h37;
    localparam logic [DATA_W-1:0] REG_STATUS = 8'hB2;
    localparam logic [DATA_W-1:0] REG_RESULT = 8'hC5;
    localparam logic [DATA_W-1:0] REG_INT    = 8'h2B;

    localparam logic [DATA_W-1:0] START_CMD    = 8'h06;
    localparam logic [DATA_W-1:0] STATUS_READY = 8'h21;
    localparam logic [DATA_W-1:0] STATUS_BUSY  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

endpackage

// File: rtl/ld3320_bus_responder_if.sv
// LD3320 parallel bus. P is carried split (host data in, responder data out, output enable);
// the pad-level tristate is P = P_oe ? P_out : 'z.
interface ld3320_bus_responder_if;
    import ld3320_bus_responder_pkg::*;

    logic              CSB;
    logic              WRB;
    logic              RDB;
    logic              A0;
    logic              RSTB;
    logic [DATA_W-1:0] P_in;
    logic [DATA_W-1:0] P_out;
    logic              P_oe;
    logic              INTB;
    logic              mon_wr;
    logic [DATA_W-1:0] mon_addr;
    logic [DATA_W-1:0] mon_data;
    logic              proto_err;

    modport slave (
        input  CSB, WRB, RDB, A0, RSTB, P_in,
        output P_out, P_oe, INTB, mon_wr, mon_addr, mon_data, proto_err
    );

    modport master (
        output CSB, WRB, RDB, A0, RSTB, P_in,
        input  P_out, P_oe, INTB, mon_wr, mon_addr, mon_data, proto_err
    );

endinterface

// File: rtl/ld3320_sync.sv
// Multi-flop synchronizer for asynchronous host signals; depth clamped to at least 2.
module ld3320_sync #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift the input through DEPTH flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
        end else begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/ld3320_bus_responder.sv
// Slave end of the LD3320 parallel interface: register file, busy/result emulation, INTB, write monitor.
module ld3320_bus_responder
    import ld3320_bus_responder_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES  = 2,
    parameter int unsigned       BUSY_CYCLES  = 16,
    parameter logic [DATA_W-1:0] RESULT_VALUE = 8'h05
) (
    input  logic                   clk,
    input  logic                   rst,
    ld3320_bus_responder_if.slave  bus
);

    logic [4:0]        w_ctl_s;
    logic              w_csb_s, w_wrb_s, w_rdb_s, w_a0_s, w_rstb_s;
    logic [DATA_W-1:0] w_p_s;
    logic              r_wrb_d, r_rdb_d;
    logic              w_wrb_fall, w_wrb_rise, w_rdb_fall, w_rdb_rise, w_conflict;

    state_t            r_state, w_next;
    logic              w_addr_en, w_data_en, w_err;
    logic              w_start, w_int_clr, w_expire;
    logic [DATA_W-1:0] w_rd_val;

    logic [DATA_W-1:0] r_addr;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_intb, r_oe, r_mon_wr, r_proto_err;
    logic [DATA_W-1:0] r_p_out, r_mon_addr, r_mon_data;
    logic [DATA_W-1:0] r_mem [256];

    ld3320_sync #(.WIDTH(5), .STAGES(SYNC_STAGES), .RST_VAL(5'b11111)) u_sync_ctl (
        .clk (clk),
        .rst (rst),
        .i_d ({bus.CSB, bus.WRB, bus.RDB, bus.A0, bus.RSTB}),
        .o_q (w_ctl_s)
    );

    // Data pipe has the same depth as the strobes so P is aligned with the WRB edge.
    ld3320_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_p (
        .clk (clk),
        .rst (rst),
        .i_d (bus.P_in),
        .o_q (w_p_s)
    );

    assign {w_csb_s, w_wrb_s, w_rdb_s, w_a0_s, w_rstb_s} = w_ctl_s;

    // One extra flop on the strobes for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrb_d <= 1'b1;
            r_rdb_d <= 1'b1;
        end else begin
            r_wrb_d <= w_wrb_s;
            r_rdb_d <= w_rdb_s;
        end
    end

    assign w_wrb_fall = ~w_wrb_s &  r_wrb_d;
    assign w_wrb_rise =  w_wrb_s & ~r_wrb_d;
    assign w_rdb_fall = ~w_rdb_s &  r_rdb_d;
    assign w_rdb_rise =  w_rdb_s & ~r_rdb_d;
    assign w_conflict = ~w_csb_s & ~w_wrb_s & ~w_rdb_s;

    assign w_start   = w_data_en & (r_addr == REG_START) & (w_p_s == START_CMD);
    assign w_int_clr = w_data_en & (r_addr == REG_INT);
    assign w_expire  = r_busy & (r_cnt == CNT_W'(1));

    // Next-state and transfer decode; chip reset and strobe conflict override everything.
    always_comb begin
        w_next    = r_state;
        w_addr_en = 1'b0;
        w_data_en = 1'b0;
        w_err     = w_conflict;
        if (!w_rstb_s || w_conflict) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_csb_s && w_wrb_fall)                 w_next = ST_WR;
                    else if (!w_csb_s && w_rdb_fall && !w_a0_s) w_next = ST_RD;
                end
                ST_WR: begin
                    if (w_wrb_rise) begin
                        w_next = ST_IDLE;
                        if (w_a0_s) w_addr_en = 1'b1;
                        else        w_data_en = 1'b1;
                    end else if (w_csb_s) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_RD:   if (w_rdb_rise || w_csb_s) w_next = ST_TURN;
                ST_TURN: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Read mux: status, result and interrupt registers are synthesized, the rest come from the RAM.
    always_comb begin
        w_rd_val = r_mem[r_addr];
        case (r_addr)
            REG_STATUS: w_rd_val = r_busy ? STATUS_BUSY : STATUS_READY;
            REG_RESULT: w_rd_val = RESULT_VALUE;
            REG_INT:    w_rd_val = {3'b000, ~r_intb, 4'b0000};
            default:    ;
        endcase
    end

    // FSM state, address, busy counter, INTB, read driver and write monitor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_intb     <= 1'b1;
            r_oe       <= 1'b0;
            r_p_out    <= '0;
            r_mon_wr   <= 1'b0;
            r_mon_addr <= '0;
            r_mon_data <= '0;
        end else if (!w_rstb_s) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_intb     <= 1'b1;
            r_oe       <= 1'b0;
            r_p_out    <= '0;
            r_mon_wr   <= 1'b0;
            r_mon_addr <= '0;
            r_mon_data <= '0;
        end else begin
            r_state  <= w_next;
            r_oe     <= (w_next == ST_RD);
            r_p_out  <= w_rd_val;
            r_mon_wr <= w_data_en;
            if (w_addr_en) r_addr <= w_p_s;
            if (w_data_en) begin
                r_mon_addr <= r_addr;
                r_mon_data <= w_p_s;
            end
            if (w_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CNT_W'(BUSY_CYCLES);
            end else if (w_expire) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_busy) begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            // An interrupt clear beats a simultaneous busy expiry.
            if (w_int_clr)                 r_intb <= 1'b1;
            else if (w_expire && !w_start) r_intb <= 1'b0;
        end
    end

    // Sticky protocol error; only the host-side rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_proto_err <= 1'b0;
        else if (w_err) r_proto_err <= 1'b1;
    end

    // Register file: synchronous write, asynchronous read, not reset.
    always_ff @(posedge clk) begin
        if (w_data_en) r_mem[r_addr] <= w_p_s;
    end

    assign bus.P_out     = r_p_out;
    assign bus.P_oe      = r_oe;
    assign bus.INTB      = r_intb;
    assign bus.mon_wr    = r_mon_wr;
    assign bus.mon_addr  = r_mon_addr;
    assign bus.mon_data  = r_mon_data;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_ld3320_bus_responder.sv
// Directed bench for ld3320_bus_responder: host strobes phase every 4 responder clocks.
module tb_ld3320_bus_responder;

    localparam int unsigned TB_BUSY = 48;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ld3320_bus_responder_if bus ();

    ld3320_bus_responder #(
        .SYNC_STAGES  (2),
        .BUSY_CYCLES  (TB_BUSY),
        .RESULT_VALUE (8'h05)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-monitor log and INTB fall timestamp.
    int         cyc;
    int         mon_cyc;
    int         intb_fall_cyc;
    logic       mon_intb;
    logic       prev_intb;
    logic [7:0] mon_q_addr[$];
    logic [7:0] mon_q_data[$];

    initial begin
        cyc = 0; mon_cyc = 0; intb_fall_cyc = 0; mon_intb = 1'b0; prev_intb = 1'b1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mon_wr === 1'b1) begin
            mon_q_addr.push_back(bus.mon_addr);
            mon_q_data.push_back(bus.mon_data);
            mon_cyc  = cyc;
            mon_intb = bus.INTB;
        end
        if (prev_intb === 1'b1 && bus.INTB === 1'b0) intb_fall_cyc = cyc;
        prev_intb = bus.INTB;
    end

    task automatic hwait();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a0, input logic [7:0] d);
        bus.A0 = a0; bus.P_in = d; bus.CSB = 1'b0; hwait();
        bus.WRB = 1'b0; hwait();
        bus.WRB = 1'b1; hwait();
        bus.CSB = 1'b1; hwait();
    endtask

    task automatic bus_read(output logic [7:0] v);
        bus.A0 = 1'b0; bus.CSB = 1'b0; hwait();
        bus.RDB = 1'b0; hwait();
        v = bus.P_out;
        bus.RDB = 1'b1; hwait();
        bus.CSB = 1'b1; hwait();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.CSB = 1'b1; bus.WRB = 1'b1; bus.RDB = 1'b1; bus.A0 = 1'b1; bus.RSTB = 1'b1; bus.P_in = 8'h00;
        hwait();
        n_vec++; if (bus.P_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", bus.P_oe); end
        n_vec++; if (bus.INTB !== 1'b1) begin n_err++; $display("FAIL reset_intb got=%b exp=1", bus.INTB); end
        n_vec++; if (bus.mon_wr !== 1'b0) begin n_err++; $display("FAIL reset_mon_wr got=%b exp=0", bus.mon_wr); end
        n_vec++; if ({bus.mon_addr, bus.mon_data} !== 16'h0000) begin n_err++;
            $display("FAIL reset_mon got=%h%h exp=0000", bus.mon_addr, bus.mon_data); end
        n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err); end
        rst = 1'b0;
        hwait();
    endtask

    task automatic test_start_busy();
        logic [7:0] v;
        int         n0;
        bit         seen;
        n0 = mon_q_addr.size();
        bus_write(1'b1, 8'h37);
        bus_write(1'b0, 8'h06);
        n_vec++; if (mon_q_addr.size() != n0 + 1) begin n_err++;
            $display("FAIL start_mon_count got=%0d exp=%0d", mon_q_addr.size(), n0 + 1); end
        n_vec++; if (mon_q_addr[$] !== 8'h37 || mon_q_data[$] !== 8'h06) begin n_err++;
            $display("FAIL start_mon_payload got=%h/%h exp=37/06", mon_q_addr[$], mon_q_data[$]); end
        bus_write(1'b1, 8'hB2);
        bus_read(v);
        n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL status_busy got=%h exp=00", v); end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.INTB === 1'b0) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        n_vec++; if (!seen) begin n_err++; $display("FAIL intb_fall got=timeout exp=fall"); end
        n_vec++; if (intb_fall_cyc - mon_cyc != int'(TB_BUSY)) begin n_err++;
            $display("FAIL busy_length got=%0d exp=%0d", intb_fall_cyc - mon_cyc, TB_BUSY); end
        bus_read(v);
        n_vec++; if (v !== 8'h21) begin n_err++; $display("FAIL status_ready got=%h exp=21", v); end
    endtask

    task automatic test_intb_clear();
        logic [7:0] v;
        bus_write(1'b1, 8'h2B);
        bus_read(v);
        n_vec++; if (v !== 8'h10) begin n_err++; $display("FAIL int_reg_pending got=%h exp=10", v); end
        n_vec++; if (bus.INTB !== 1'b0) begin n_err++; $display("FAIL intb_before_clear got=%b exp=0", bus.INTB); end
        bus_write(1'b0, 8'h00);
        n_vec++; if (mon_intb !== 1'b1) begin n_err++; $display("FAIL intb_at_mon_wr got=%b exp=1", mon_intb); end
        bus_read(v);
        n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL int_reg_cleared got=%h exp=00", v); end
    endtask

    task automatic test_read_turn();
        bus_write(1'b1, 8'h05);
        bus_write(1'b0, 8'hA5);
        n_vec++; if (mon_q_addr[$] !== 8'h05 || mon_q_data[$] !== 8'hA5) begin n_err++;
            $display("FAIL reg_write_mon got=%h/%h exp=05/A5", mon_q_addr[$], mon_q_data[$]); end
        bus.A0 = 1'b0; bus.CSB = 1'b0; hwait();
        bus.RDB = 1'b0; hwait();
        n_vec++; if (bus.P_oe !== 1'b1 || bus.P_out !== 8'hA5) begin n_err++;
            $display("FAIL reg_read got=oe%b/%h exp=oe1/A5", bus.P_oe, bus.P_out); end
        bus.RDB = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_vec++; if (bus.P_oe !== 1'b1) begin n_err++; $display("FAIL oe_before_turn got=%b exp=1", bus.P_oe); end
        @(posedge clk); #1;
        n_vec++; if (bus.P_oe !== 1'b0) begin n_err++; $display("FAIL oe_turn got=%b exp=0", bus.P_oe); end
        bus.CSB = 1'b1; hwait();
    endtask

    task automatic test_abort_proto();
        logic [7:0] v;
        int         n0;
        n0 = mon_q_addr.size();
        bus.A0 = 1'b0; bus.P_in = 8'h5A; bus.CSB = 1'b0; hwait();
        bus.WRB = 1'b0; hwait();
        bus.CSB = 1'b1; hwait();
        bus.WRB = 1'b1; hwait();
        n_vec++; if (mon_q_addr.size() != n0) begin n_err++;
            $display("FAIL abort_no_write got=%0d exp=%0d", mon_q_addr.size(), n0); end
        bus_read(v);
        n_vec++; if (v !== 8'hA5) begin n_err++; $display("FAIL abort_reg_kept got=%h exp=A5", v); end
        bus.A0 = 1'b0; bus.CSB = 1'b0; hwait();
        bus.RDB = 1'b0; hwait();
        bus.WRB = 1'b0; hwait();
        n_vec++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err got=%b exp=1", bus.proto_err); end
        n_vec++; if (bus.P_oe !== 1'b0) begin n_err++; $display("FAIL proto_oe got=%b exp=0", bus.P_oe); end
        bus.WRB = 1'b1; bus.RDB = 1'b1; hwait();
        bus.CSB = 1'b1; hwait();
        n_vec++; if (mon_q_addr.size() != n0) begin n_err++;
            $display("FAIL proto_no_write got=%0d exp=%0d", mon_q_addr.size(), n0); end
    endtask

    task automatic test_rstb_rst();
        logic [7:0] v;
        bit         intb_ok;
        bus_write(1'b1, 8'h00);
        bus_write(1'b0, 8'h3C);
        bus_write(1'b1, 8'h37);
        bus_write(1'b0, 8'h06);
        bus.RSTB = 1'b0; hwait();
        n_vec++; if ({bus.mon_addr, bus.mon_data} !== 16'h0000) begin n_err++;
            $display("FAIL rstb_mon got=%h%h exp=0000", bus.mon_addr, bus.mon_data); end
        n_vec++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL rstb_proto_kept got=%b exp=1", bus.proto_err); end
        bus.RSTB = 1'b1; hwait();
        intb_ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.INTB !== 1'b1) intb_ok = 1'b0;
        end
        n_vec++; if (!intb_ok) begin n_err++; $display("FAIL rstb_busy_cleared got=intb_fell exp=intb_high"); end
        bus_read(v);
        n_vec++; if (v !== 8'h3C) begin n_err++; $display("FAIL rstb_addr_zero got=%h exp=3C", v); end
        bus_write(1'b1, 8'hB2);
        bus_read(v);
        n_vec++; if (v !== 8'h21) begin n_err++; $display("FAIL rstb_status got=%h exp=21", v); end
        bus.A0 = 1'b0; bus.CSB = 1'b0; hwait();
        bus.RDB = 1'b0; hwait();
        n_vec++; if (bus.P_oe !== 1'b1) begin n_err++; $display("FAIL mid_read_oe got=%b exp=1", bus.P_oe); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.P_oe !== 1'b0) begin n_err++; $display("FAIL rst_releases_p got=%b exp=0", bus.P_oe); end
        n_vec++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL rst_proto_clr got=%b exp=0", bus.proto_err); end
        bus.RDB = 1'b1; bus.CSB = 1'b1; hwait();
        rst = 1'b0; hwait();
    endtask

    task automatic test_result_back_to_back();
        logic [7:0] v;
        logic [7:0] dat [3];
        int         n0;
        bus_write(1'b1, 8'hC5);
        bus_read(v);
        n_vec++; if (v !== 8'h05) begin n_err++; $display("FAIL result_reg got=%h exp=05", v); end
        bus.A0 = 1'b1; bus.CSB = 1'b0; bus.RDB = 1'b0; hwait();
        n_vec++; if (bus.P_oe !== 1'b0) begin n_err++; $display("FAIL read_a0_ignored got=%b exp=0", bus.P_oe); end
        bus.RDB = 1'b1; hwait();
        bus.CSB = 1'b1; hwait();
        bus_write(1'b1, 8'h10);
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        n0 = mon_q_addr.size();
        bus.A0 = 1'b0; bus.CSB = 1'b0; hwait();
        for (int i = 0; i < 3; i++) begin
            bus.P_in = dat[i]; bus.WRB = 1'b0; hwait();
            bus.WRB = 1'b1; hwait();
        end
        bus.CSB = 1'b1; hwait();
        n_vec++; if (mon_q_addr.size() != n0 + 3) begin n_err++;
            $display("FAIL b2b_count got=%0d exp=%0d", mon_q_addr.size(), n0 + 3); end
        for (int i = 0; i < 3; i++) begin
            if (n0 + i < mon_q_addr.size()) begin
                n_vec++;
                if (mon_q_addr[n0+i] !== 8'h10 || mon_q_data[n0+i] !== dat[i]) begin n_err++;
                    $display("FAIL b2b_write%0d got=%h/%h exp=10/%h", i, mon_q_addr[n0+i], mon_q_data[n0+i], dat[i]); end
            end
        end
        bus_read(v);
        n_vec++; if (v !== 8'h33) begin n_err++; $display("FAIL b2b_readback got=%h exp=33", v); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_start_busy();
        test_intb_clear();
        test_read_turn();
        test_abort_proto();
        test_rstb_rst();
        test_result_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
